truth_table_sweeper: RTL and testbench

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

---
 rtl/truth_table_sweeper_pkg.sv | 21 ++
 rtl/truth_table_sweeper_settle.sv | 31 +++
 rtl/truth_table_sweeper.sv | 151 +++++++++++++++
 tb/tb_truth_table_sweeper.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper: FSM states, sweep
// dimensions and the default expected truth table.
package truth_table_sweeper_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int N_IN  = 5;
  localparam int N_VEC = 32;

  // Expected table for the golden 5-input function; bit i is vector i.
  localparam logic [N_VEC-1:0] EXPECT_DEFAULT = 32'hA2A02255;

  // Index of the final vector in a sweep.
  localparam logic [N_IN-1:0] LAST_VEC = 5'(N_VEC - 1);

endpackage

// File: rtl/truth_table_sweeper_settle.sv
// Settle timer: counts the cycles an input vector has been held and flags
// the cycle in which the hold time reaches SETTLE.
module sweep_settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [3:0] cnt_q;

  // Settle counter: cleared outside APPLY, advances once per APPLY cycle.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      cnt_q <= 4'd0;
    end else if (clear) begin
      cnt_q <= 4'd0;
    end else if (enable) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

  // High in the last of the SETTLE hold cycles.
  assign expired = (cnt_q == 4'(SETTLE - 1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives every 5-bit vector into an external
// combinational function, samples its output after a settle time, and
// compares the captured table against an expected one.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int               SETTLE = 2,
  parameter logic [N_VEC-1:0] EXPECT = EXPECT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             f_in,
  output logic [N_IN-1:0]  vec,
  output logic             busy,
  output logic             done,
  output logic [N_VEC-1:0] tt,
  output logic [5:0]       mismatch_cnt,
  output logic [N_IN-1:0]  first_fail,
  output logic             fail_valid,
  output logic             match
);

  state_t state_q, state_d;

  logic             accept;     // start taken in IDLE this edge
  logic             sample;     // SAMPLE edge that records f_in
  logic             abort_hit;  // sweep cancelled this edge
  logic             settled;
  logic             miss;

  logic [N_IN-1:0]  vec_q;
  logic [N_VEC-1:0] tt_q;
  logic [5:0]       mismatch_q;
  logic [N_IN-1:0]  first_fail_q;
  logic             fail_valid_q;
  logic             match_q;

  sweep_settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q != APPLY),
    .enable  (state_q == APPLY),
    .expired (settled)
  );

  assign miss = (f_in != EXPECT[vec_q]);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and per-edge control strobes; abort outranks sampling.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    accept    = 1'b0;
    sample    = 1'b0;
    abort_hit = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = APPLY;
        end
      end
      APPLY: begin
        busy = 1'b1;
        if (abort) begin
          abort_hit = 1'b1;
          state_d   = IDLE;
        end else if (settled) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        busy = 1'b1;
        if (abort) begin
          abort_hit = 1'b1;
          state_d   = IDLE;
        end else begin
          sample  = 1'b1;
          state_d = (vec_q == LAST_VEC) ? DONE : APPLY;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sweep datapath: vector index, captured table and mismatch bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_q        <= '0;
      tt_q         <= '0;
      mismatch_q   <= '0;
      first_fail_q <= '0;
      fail_valid_q <= 1'b0;
      match_q      <= 1'b0;
    end else if (accept) begin
      vec_q        <= '0;
      tt_q         <= '0;
      mismatch_q   <= '0;
      first_fail_q <= '0;
      fail_valid_q <= 1'b0;
      match_q      <= 1'b0;
    end else if (abort_hit) begin
      // Partial table and counts stay visible for debug.
      vec_q   <= '0;
      match_q <= 1'b0;
    end else if (sample) begin
      tt_q[vec_q] <= f_in;
      // At most one increment per vector, so the count tops out at 32.
      if (miss) begin
        mismatch_q <= mismatch_q + 6'd1;
      end
      if (miss && !fail_valid_q) begin
        first_fail_q <= vec_q;
        fail_valid_q <= 1'b1;
      end
      if (vec_q != LAST_VEC) begin
        vec_q <= vec_q + 5'd1;
      end else begin
        // Match is decided on the edge entering DONE so it lines up with done.
        match_q <= (mismatch_q == 6'd0) && !miss;
      end
    end
  end

  assign vec          = vec_q;
  assign tt           = tt_q;
  assign mismatch_cnt = mismatch_q;
  assign first_fail   = first_fail_q;
  assign fail_valid   = fail_valid_q;
  assign match        = match_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Testbench for truth_table_sweeper: table-driven full sweeps plus directed
// sequences for abort, start handling and asynchronous reset.
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        f_in;
  logic [4:0]  vec;
  logic        busy;
  logic        done;
  logic [31:0] tt;
  logic [5:0]  mismatch_cnt;
  logic [4:0]  first_fail;
  logic        fail_valid;
  logic        match;

  // Function under test: 0 = golden function, 1 = stuck at 0, 2 = stuck at 1.
  int          mode;
  logic [31:0] golden;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always_comb begin
    f_in = 1'b0;
    case (mode)
      0:       f_in = golden[vec];
      2:       f_in = 1'b1;
      default: f_in = 1'b0;
    endcase
  end

  truth_table_sweeper dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .f_in         (f_in),
    .vec          (vec),
    .busy         (busy),
    .done         (done),
    .tt           (tt),
    .mismatch_cnt (mismatch_cnt),
    .first_fail   (first_fail),
    .fail_valid   (fail_valid),
    .match        (match)
  );

  typedef struct {
    int          m;
    logic [31:0] exp_tt;
    logic [31:0] exp_cnt;
    logic [31:0] exp_ff;
    logic [31:0] exp_fv;
    logic [31:0] exp_match;
  } vector_t;

  vector_t vectors[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Start a sweep in IDLE and return the number of edges from the accept
  // edge until done is seen (-1 if it never comes). Optionally keep start
  // high, or re-pulse it after a given number of edges.
  task automatic run_sweep(input bit hold, input int pulse_at, output int lat);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    lat = -1;
    for (int i = 0; i <= 200; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
      if (i == pulse_at) start = 1'b1;
      else if (!hold) start = 1'b0;
    end
  endtask

  // Count done pulses over a window of cycles.
  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
  endtask

  // Wait at negedges until vec reaches a value while busy; false on timeout.
  task automatic wait_vec(input logic [4:0] v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy && vec == v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " vec"},        32'(vec), 32'd0);
    check({tag, " tt"},         tt, 32'd0);
    check({tag, " flags"},      32'({busy, done, fail_valid, match}), 32'd0);
    check({tag, " counts"},     32'({mismatch_cnt, first_fail}), 32'd0);
  endtask

  initial begin
    int  lat;
    int  pulses;
    bit  ok;

    golden = 32'hA2A02255;
    //                 mode exp_tt         cnt  ff  fv  match
    vectors[0] = '{0, 32'hA2A02255, 0,  0,  0,  1};
    vectors[1] = '{1, 32'h00000000, 11, 0,  1,  0};
    vectors[2] = '{2, 32'hFFFFFFFF, 21, 1,  1,  0};

    mode  = 0;
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b1;
    #2;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Full sweeps against the three functions.
    foreach (vectors[k]) begin
      mode = vectors[k].m;
      run_sweep(1'b0, -1, lat);
      check($sformatf("sweep%0d latency", k), 32'(lat), 32'd96);
      check($sformatf("sweep%0d tt", k), tt, vectors[k].exp_tt);
      check($sformatf("sweep%0d mismatch_cnt", k), 32'(mismatch_cnt), vectors[k].exp_cnt);
      check($sformatf("sweep%0d first_fail", k), 32'(first_fail), vectors[k].exp_ff);
      check($sformatf("sweep%0d fail_valid", k), 32'(fail_valid), vectors[k].exp_fv);
      check($sformatf("sweep%0d match", k), 32'(match), vectors[k].exp_match);
      @(negedge clk);
      check($sformatf("sweep%0d done one cycle", k), 32'(done), 32'd0);
    end

    // Abort in APPLY at vec 10.
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_vec(5'd10, ok);
    check("abort reach vec10", 32'(ok), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort vec", 32'(vec), 32'd0);
    check("abort tt", tt, 32'h00000255);
    check("abort match", 32'(match), 32'd0);
    count_done(120, pulses);
    check("abort no done", 32'(pulses), 32'd0);

    // Abort on the final SAMPLE edge wins over completion.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_vec(5'd31, ok);
    check("last abort reach vec31", 32'(ok), 32'd1);
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("last abort busy/done", 32'({busy, done}), 32'd0);
    check("last abort vec", 32'(vec), 32'd0);
    check("last abort tt", tt, 32'h22A02255);
    check("last abort match", 32'(match), 32'd0);
    count_done(20, pulses);
    check("last abort no done", 32'(pulses), 32'd0);

    // Abort in IDLE has no effect on a later sweep.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    run_sweep(1'b0, -1, lat);
    check("idle abort latency", 32'(lat), 32'd96);
    check("idle abort match", 32'(match), 32'd1);

    // Start re-pulsed mid-sweep is ignored.
    run_sweep(1'b0, 40, lat);
    check("repulse latency", 32'(lat), 32'd96);
    check("repulse tt", tt, 32'hA2A02255);

    // Start held high: a second sweep follows DONE through IDLE.
    run_sweep(1'b1, -1, lat);
    check("hold first latency", 32'(lat), 32'd96);
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (busy) begin
        lat = i;
        break;
      end
    end
    check("hold restart gap", 32'(lat), 32'd2);
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
    end
    start = 1'b0;
    check("hold second latency", 32'(lat), 32'd96);
    check("hold second match", 32'(match), 32'd1);
    @(negedge clk);

    // Asynchronous reset mid-sweep at vec 20.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_vec(5'd20, ok);
    check("rst reach vec20", 32'(ok), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_all_zero("async rst");
    @(negedge clk);
    rst = 1'b0;
    run_sweep(1'b0, -1, lat);
    check("post rst latency", 32'(lat), 32'd96);
    check("post rst tt", tt, 32'hA2A02255);
    check("post rst mismatch_cnt", 32'(mismatch_cnt), 32'd0);
    check("post rst match", 32'(match), 32'd1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
